// File: rtl/garland_sched.sv
// garland_sched: lamp step sequencer, mode button debouncer and
// red/green run-token arbiter for the garland lamp driver.
module garland_sched #(
   parameter int TICK_DIV = 25,
   parameter int W        = 5,
   parameter int DEB_LEN  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         btn_mode,
   input  logic         pause,
   output logic [1:0]   mode,
   output logic [W-1:0] red,
   output logic [W-1:0] green,
   output logic         r_task,
   output logic         g_task,
   output logic         step
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int IW = $clog2(W);
   localparam int DW = $clog2(DEB_LEN + 1);

   localparam logic [1:0] M_CHASE = 2'd0;
   localparam logic [1:0] M_PING  = 2'd1;
   localparam logic [1:0] M_OFF   = 2'd2;

   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [IW-1:0] POS_MAX = IW'(W - 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_LEN - 1);
   localparam logic [W-1:0]  ONE     = W'(1);

   typedef enum logic [1:0] {IDLE, RED, GREEN} arb_t;

   logic          btn_s1, btn_s2;
   logic          deb, deb_q;
   logic [DW-1:0] deb_cnt;
   logic [PW-1:0] pre, pre_nxt;
   logic [IW-1:0] rpos, rpos_nxt;
   logic [IW-1:0] gpos, gpos_nxt;
   arb_t          arb, arb_nxt;
   logic [1:0]    mode_nxt;
   logic [W-1:0]  red_nxt, green_nxt;
   logic          r_nxt, g_nxt, step_nxt;
   logic          adv, run, tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
         deb     <= 1'b0;
         deb_q   <= 1'b0;
         deb_cnt <= '0;
      end else begin
         btn_s1 <= btn_mode;
         btn_s2 <= btn_s1;
         deb_q  <= deb;
         if (btn_s2 == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_MAX) begin
            deb     <= btn_s2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

   // only the press edge of the debounced button advances the mode
   assign adv  = deb & ~deb_q;
   assign run  = (mode != M_OFF) && !pause;
   assign tick = run && (pre == PRE_MAX);

   always_comb begin
      mode_nxt  = mode;
      red_nxt   = red;
      green_nxt = green;
      r_nxt     = r_task;
      g_nxt     = g_task;
      step_nxt  = 1'b0;
      pre_nxt   = pre;
      rpos_nxt  = rpos;
      gpos_nxt  = gpos;
      arb_nxt   = arb;
      if (run)
         pre_nxt = tick ? '0 : pre + PW'(1);
      if (adv) begin
         mode_nxt  = (mode == M_OFF) ? M_CHASE : mode + 2'd1;
         red_nxt   = '0;
         green_nxt = '0;
         r_nxt     = 1'b0;
         g_nxt     = 1'b0;
         pre_nxt   = '0;
         rpos_nxt  = '0;
         gpos_nxt  = POS_MAX;
         arb_nxt   = IDLE;
      end else if (tick) begin
         step_nxt = 1'b1;
         if (mode == M_CHASE) begin
            red_nxt   = ONE << rpos;
            green_nxt = ONE << gpos;
            rpos_nxt  = (rpos == POS_MAX) ? '0 : rpos + IW'(1);
            gpos_nxt  = (gpos == '0) ? POS_MAX : gpos - IW'(1);
         end else if (mode == M_PING) begin
            case (arb)
               IDLE: begin
                  r_nxt     = 1'b1;
                  g_nxt     = 1'b0;
                  rpos_nxt  = POS_MAX;
                  red_nxt   = '0;
                  green_nxt = '0;
                  arb_nxt   = RED;
               end
               RED: begin
                  red_nxt   = ONE << rpos;
                  green_nxt = '0;
                  if (rpos == '0) begin
                     arb_nxt  = GREEN;
                     r_nxt    = 1'b0;
                     g_nxt    = 1'b1;
                     gpos_nxt = '0;
                  end else begin
                     rpos_nxt = rpos - IW'(1);
                  end
               end
               GREEN: begin
                  green_nxt = ONE << gpos;
                  red_nxt   = '0;
                  if (gpos == POS_MAX) begin
                     arb_nxt  = RED;
                     r_nxt    = 1'b1;
                     g_nxt    = 1'b0;
                     rpos_nxt = POS_MAX;
                  end else begin
                     gpos_nxt = gpos + IW'(1);
                  end
               end
               default: arb_nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode   <= M_CHASE;
         red    <= '0;
         green  <= '0;
         r_task <= 1'b0;
         g_task <= 1'b0;
         step   <= 1'b0;
         pre    <= '0;
         rpos   <= '0;
         gpos   <= POS_MAX;
         arb    <= IDLE;
      end else begin
         mode   <= mode_nxt;
         red    <= red_nxt;
         green  <= green_nxt;
         r_task <= r_nxt;
         g_task <= g_nxt;
         step   <= step_nxt;
         pre    <= pre_nxt;
         rpos   <= rpos_nxt;
         gpos   <= gpos_nxt;
         arb    <= arb_nxt;
      end
   end
endmodule
